rom_read_sequencer: RTL

Synchronous read controller that drives the asynchronous fixed-memory ROM chip on the fixed/erasable memory board. Accepts one 17-bit word-address request at a time from the memory-interface logic and sequences CE_/OE_/address. After a fixed access window it captures the 16-bit DQ word and returns it with a one-cycle valid strobe. It also returns odd-parity and blank-word status. WE_ is never asserted: the ROM is read-only in this design.

---
 rtl/rom_read_sequencer_pkg.sv | 17 +
 rtl/rom_word_check.sv | 14 +
 rtl/rom_read_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/rom_read_sequencer_pkg.sv
// Shared ROM bus definitions: state encodings, bus widths and the blank-word value.
// The ROM model and the erasable-memory controller import the same package.
package rom_read_sequencer_pkg;

  localparam int ROM_AW = 17;
  localparam int ROM_DW = 16;

  localparam logic [ROM_DW-1:0] ROM_BLANK = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RECOVER = 2'd3
  } rom_state_e;

endpackage

// File: rtl/rom_word_check.sv
// Combinational status for a ROM word: blank (unprogrammed) and even-parity error.
module rom_word_check
  import rom_read_sequencer_pkg::*;
(
  input  logic [ROM_DW-1:0] w,
  output logic              blank,
  output logic              perr
);

  assign blank = (w == ROM_BLANK);
  // ROM words are stored with odd parity; a blank word is not a parity error.
  assign perr  = ~(^w) & ~blank;

endmodule

// File: rtl/rom_read_sequencer.sv
// Read sequencer for the asynchronous fixed-memory ROM: drives CE_/OE_/A, waits a
// fixed access window, captures DQ and returns it with a one-cycle RVALID strobe.
module rom_read_sequencer
  import rom_read_sequencer_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST_,
  input  logic              REQ,
  input  logic [ROM_AW-1:0] ADDR,
  output logic              READY,
  output logic              RVALID,
  output logic [ROM_DW-1:0] RDATA,
  output logic              PERR,
  output logic              BLANK,
  output logic              CE_,
  output logic              OE_,
  output logic              WE_,
  output logic [ROM_AW-1:0] A,
  input  logic [ROM_DW-1:0] DQ,
  output logic [1:0]        state_dbg
);

  // Handshake: a request is taken on a rising edge where REQ=1 and READY=1.
  // REQ seen while READY=0 is dropped, not queued; ADDR is only sampled on that edge.

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  rom_state_e state;
  logic [3:0] cnt;
  logic       chk_blank;
  logic       chk_perr;

  rom_word_check u_word_check (
    .w     (DQ),
    .blank (chk_blank),
    .perr  (chk_perr)
  );

  assign WE_       = 1'b1;
  assign state_dbg = state;

  always_ff @(posedge CLK) begin
    if (!RST_) begin
      state  <= IDLE;
      cnt    <= '0;
      CE_    <= 1'b1;
      OE_    <= 1'b1;
      A      <= '0;
      RDATA  <= '0;
      RVALID <= 1'b0;
      PERR   <= 1'b0;
      BLANK  <= 1'b0;
      READY  <= 1'b1;
    end else begin
      RVALID <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ) begin
            A     <= ADDR;
            CE_   <= 1'b0;
            READY <= 1'b0;
            state <= SETUP;
          end
        end
        SETUP: begin
          OE_   <= 1'b0;
          cnt   <= WAIT_LOAD;
          state <= ACCESS;
        end
        ACCESS: begin
          // DQ only reaches the output registers here, so Z/X elsewhere is harmless.
          if (cnt == 4'd0) begin
            RDATA  <= DQ;
            BLANK  <= chk_blank;
            PERR   <= chk_perr;
            RVALID <= 1'b1;
            CE_    <= 1'b1;
            OE_    <= 1'b1;
            state  <= RECOVER;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RECOVER: begin
          READY <= 1'b1;
          state <= IDLE;
        end
        default: begin
          CE_   <= 1'b1;
          OE_   <= 1'b1;
          READY <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
